// File: rtl/pf_replay_buffer.sv
`default_nettype none
// ============================================================================
// Module   : pf_replay_buffer
// Purpose  : Request pipeline stage that parks a page-faulting request,
//            raises an interrupt, and on software command either re-translates
//            and replays the request downstream or aborts it with an error
//            notification. Software control is through an AHB-lite slave.
// Ports    : CLK, nRST (async, active-high)
//            req_*      upstream request (valid/ready handshake)
//            mem_req_*  downstream request from a one-entry output register
//            xlate_*    same-cycle page-table re-lookup used during retry
//            err_*      one-cycle abort notification
//            irq        fault-pending interrupt
//            H*         AHB-lite slave: STATUS, FAULT_VADDR, FAULT_TAG, CMD
// Revision : 1.0 - initial release
// ============================================================================
module pf_replay_buffer #(
  parameter int TAG_W  = 4,
  parameter int ADDR_W = 32
) (
  input  logic              CLK,
  input  logic              nRST,
  // upstream request
  input  logic              req_valid,
  input  logic              req_rw,
  output logic              req_ready,
  input  logic [ADDR_W-1:0] req_vaddr,
  input  logic [ADDR_W-1:0] req_paddr,
  input  logic [ADDR_W-1:0] req_wdata,
  input  logic              req_fault,
  input  logic [TAG_W-1:0]  req_tag,
  // downstream request
  output logic              mem_req_valid,
  output logic              mem_req_rw,
  input  logic              mem_req_ready,
  output logic [ADDR_W-1:0] mem_req_addr,
  output logic [ADDR_W-1:0] mem_req_data,
  output logic [TAG_W-1:0]  mem_req_tag,
  // translation re-lookup
  output logic              xlate_valid,
  output logic [ADDR_W-1:0] xlate_vaddr,
  input  logic [ADDR_W-1:0] xlate_paddr,
  input  logic              xlate_fault,
  // abort notification and interrupt
  output logic              err_valid,
  output logic [TAG_W-1:0]  err_tag,
  output logic              irq,
  // AHB-lite slave
  input  logic              HSEL,
  input  logic              HWRITE,
  input  logic [1:0]        HTRANS,
  input  logic [31:0]       HADDR,
  input  logic [31:0]       HWDATA,
  output logic [31:0]       HRDATA,
  output logic              HREADYOUT,
  output logic              HRESP
);

  typedef enum logic [1:0] {
    ST_PASS       = 2'd0,
    ST_FAULT_WAIT = 2'd1,
    ST_RETRY      = 2'd2,
    ST_REPLAY     = 2'd3
  } state_t;

  localparam logic [1:0] c_HTRANS_NONSEQ = 2'b10;
  localparam logic [2:0] c_IDX_STATUS    = 3'd0;
  localparam logic [2:0] c_IDX_VADDR     = 3'd1;
  localparam logic [2:0] c_IDX_TAG       = 3'd2;
  localparam logic [2:0] c_IDX_CMD       = 3'd3;

  state_t              state_q, state_d;

  // one-entry output register
  logic                out_valid_q, out_valid_d;
  logic [ADDR_W-1:0]   out_addr_q,  out_addr_d;
  logic [ADDR_W-1:0]   out_data_q,  out_data_d;
  logic                out_rw_q,    out_rw_d;
  logic [TAG_W-1:0]    out_tag_q,   out_tag_d;

  // parked (faulting) request
  logic [ADDR_W-1:0]   hold_vaddr_q, hold_vaddr_d;
  logic [ADDR_W-1:0]   hold_wdata_q, hold_wdata_d;
  logic                hold_rw_q,    hold_rw_d;
  logic [TAG_W-1:0]    hold_tag_q,   hold_tag_d;
  logic [ADDR_W-1:0]   replay_paddr_q, replay_paddr_d;

  logic [7:0]          retry_cnt_q, retry_cnt_d;
  logic                irq_q,       irq_d;
  logic                err_valid_q, err_valid_d;
  logic [TAG_W-1:0]    err_tag_q,   err_tag_d;

  // AHB address-phase registers
  logic                ahb_sel_q,   ahb_sel_d;
  logic                ahb_write_q, ahb_write_d;
  logic [2:0]          ahb_idx_q,   ahb_idx_d;

  logic                w_out_free;
  logic                w_accept;
  logic                w_cmd_wr;
  logic                w_cmd_abort;
  logic                w_cmd_retry;
  logic                w_pending;
  logic [31:0]         w_status;

  // Output slot can take a new entry if empty or being drained this cycle.
  assign w_out_free = ~out_valid_q | mem_req_ready;
  assign req_ready  = (state_q == ST_PASS) & w_out_free;
  assign w_accept   = req_valid & req_ready;

  // CMD takes effect in the data phase of a write to word 3.
  assign w_cmd_wr    = ahb_sel_q & ahb_write_q & (ahb_idx_q == c_IDX_CMD);
  assign w_cmd_abort = w_cmd_wr & HWDATA[1];
  assign w_cmd_retry = w_cmd_wr & HWDATA[0] & ~HWDATA[1];

  assign w_pending = (state_q != ST_PASS);
  assign w_status  = {16'h0000, retry_cnt_q, 6'b000000, irq_q, w_pending};

  always_comb begin
    state_d        = state_q;
    out_valid_d    = out_valid_q;
    out_addr_d     = out_addr_q;
    out_data_d     = out_data_q;
    out_rw_d       = out_rw_q;
    out_tag_d      = out_tag_q;
    hold_vaddr_d   = hold_vaddr_q;
    hold_wdata_d   = hold_wdata_q;
    hold_rw_d      = hold_rw_q;
    hold_tag_d     = hold_tag_q;
    replay_paddr_d = replay_paddr_q;
    retry_cnt_d    = retry_cnt_q;
    irq_d          = irq_q;
    err_valid_d    = 1'b0;
    err_tag_d      = err_tag_q;

    // The output register drains regardless of what the FSM is doing;
    // a load below overrides the drain when both happen in one cycle.
    if (out_valid_q && mem_req_ready) begin
      out_valid_d = 1'b0;
    end

    case (state_q)
      ST_PASS: begin
        if (w_accept) begin
          if (req_fault) begin
            hold_vaddr_d = req_vaddr;
            hold_wdata_d = req_wdata;
            hold_rw_d    = req_rw;
            hold_tag_d   = req_tag;
            irq_d        = 1'b1;
            retry_cnt_d  = 8'd0;
            state_d      = ST_FAULT_WAIT;
          end else begin
            out_valid_d = 1'b1;
            out_addr_d  = req_paddr;
            out_data_d  = req_wdata;
            out_rw_d    = req_rw;
            out_tag_d   = req_tag;
          end
        end
      end
      ST_FAULT_WAIT: begin
        // abort wins when both command bits are set
        if (w_cmd_abort) begin
          err_valid_d = 1'b1;
          err_tag_d   = hold_tag_q;
          irq_d       = 1'b0;
          state_d     = ST_PASS;
        end else if (w_cmd_retry) begin
          irq_d   = 1'b0;
          state_d = ST_RETRY;
        end
      end
      ST_RETRY: begin
        if (xlate_fault) begin
          if (retry_cnt_q != 8'hFF) begin
            retry_cnt_d = retry_cnt_q + 8'd1;
          end
          irq_d   = 1'b1;
          state_d = ST_FAULT_WAIT;
        end else begin
          replay_paddr_d = xlate_paddr;
          state_d        = ST_REPLAY;
        end
      end
      ST_REPLAY: begin
        if (w_out_free) begin
          out_valid_d = 1'b1;
          out_addr_d  = replay_paddr_q;
          out_data_d  = hold_wdata_q;
          out_rw_d    = hold_rw_q;
          out_tag_d   = hold_tag_q;
          state_d     = ST_PASS;
        end
      end
      default: begin
        state_d = ST_PASS;
      end
    endcase
  end

  always_comb begin
    ahb_sel_d   = HSEL & (HTRANS == c_HTRANS_NONSEQ);
    ahb_write_d = HWRITE;
    ahb_idx_d   = HADDR[4:2];
  end

  always_ff @(posedge CLK or posedge nRST) begin
    if (nRST) begin
      state_q        <= ST_PASS;
      out_valid_q    <= 1'b0;
      out_addr_q     <= '0;
      out_data_q     <= '0;
      out_rw_q       <= 1'b0;
      out_tag_q      <= '0;
      hold_vaddr_q   <= '0;
      hold_wdata_q   <= '0;
      hold_rw_q      <= 1'b0;
      hold_tag_q     <= '0;
      replay_paddr_q <= '0;
      retry_cnt_q    <= 8'd0;
      irq_q          <= 1'b0;
      err_valid_q    <= 1'b0;
      err_tag_q      <= '0;
      ahb_sel_q      <= 1'b0;
      ahb_write_q    <= 1'b0;
      ahb_idx_q      <= 3'd0;
    end else begin
      state_q        <= state_d;
      out_valid_q    <= out_valid_d;
      out_addr_q     <= out_addr_d;
      out_data_q     <= out_data_d;
      out_rw_q       <= out_rw_d;
      out_tag_q      <= out_tag_d;
      hold_vaddr_q   <= hold_vaddr_d;
      hold_wdata_q   <= hold_wdata_d;
      hold_rw_q      <= hold_rw_d;
      hold_tag_q     <= hold_tag_d;
      replay_paddr_q <= replay_paddr_d;
      retry_cnt_q    <= retry_cnt_d;
      irq_q          <= irq_d;
      err_valid_q    <= err_valid_d;
      err_tag_q      <= err_tag_d;
      ahb_sel_q      <= ahb_sel_d;
      ahb_write_q    <= ahb_write_d;
      ahb_idx_q      <= ahb_idx_d;
    end
  end

  // Read data is driven only during the data phase of a selected read.
  always_comb begin
    HRDATA = 32'h0000_0000;
    if (ahb_sel_q && !ahb_write_q) begin
      case (ahb_idx_q)
        c_IDX_STATUS: HRDATA = w_status;
        c_IDX_VADDR:  HRDATA = 32'(hold_vaddr_q);
        c_IDX_TAG:    HRDATA = 32'(hold_tag_q);
        default:      HRDATA = 32'h0000_0000;
      endcase
    end
  end

  assign HREADYOUT = 1'b1;
  assign HRESP     = 1'b0;

  assign mem_req_valid = out_valid_q;
  assign mem_req_addr  = out_addr_q;
  assign mem_req_data  = out_data_q;
  assign mem_req_rw    = out_rw_q;
  assign mem_req_tag   = out_tag_q;

  assign xlate_valid = (state_q == ST_RETRY);
  assign xlate_vaddr = hold_vaddr_q;

  assign err_valid = err_valid_q;
  assign err_tag   = err_tag_q;
  assign irq       = irq_q;

  // Address bits outside the register window and unused command bits.
  logic w_unused_ok;
  assign w_unused_ok = &{1'b0, HADDR[31:5], HADDR[1:0], HWDATA[31:2]};

endmodule
`default_nettype wire

// File: tb/tb_pf_replay_buffer.sv
`default_nettype none
// ============================================================================
// Module   : tb_pf_replay_buffer
// Purpose  : Self-checking bench for pf_replay_buffer: directed scenarios with
//            literal expectations, then randomized traffic compared every
//            cycle against a transaction-level reference model.
// Revision : 1.0 - initial release
// ============================================================================
module tb_pf_replay_buffer;

  localparam int TAG_W  = 4;
  localparam int ADDR_W = 32;

  logic              CLK;
  logic              nRST;
  logic              req_valid, req_rw, req_ready, req_fault;
  logic [ADDR_W-1:0] req_vaddr, req_paddr, req_wdata;
  logic [TAG_W-1:0]  req_tag;
  logic              mem_req_valid, mem_req_rw, mem_req_ready;
  logic [ADDR_W-1:0] mem_req_addr, mem_req_data;
  logic [TAG_W-1:0]  mem_req_tag;
  logic              xlate_valid, xlate_fault;
  logic [ADDR_W-1:0] xlate_vaddr, xlate_paddr;
  logic              err_valid, irq;
  logic [TAG_W-1:0]  err_tag;
  logic              HSEL, HWRITE, HREADYOUT, HRESP;
  logic [1:0]        HTRANS;
  logic [31:0]       HADDR, HWDATA, HRDATA;

  pf_replay_buffer #(.TAG_W(TAG_W), .ADDR_W(ADDR_W)) dut (
    .CLK(CLK), .nRST(nRST),
    .req_valid(req_valid), .req_rw(req_rw), .req_ready(req_ready),
    .req_vaddr(req_vaddr), .req_paddr(req_paddr), .req_wdata(req_wdata),
    .req_fault(req_fault), .req_tag(req_tag),
    .mem_req_valid(mem_req_valid), .mem_req_rw(mem_req_rw),
    .mem_req_ready(mem_req_ready), .mem_req_addr(mem_req_addr),
    .mem_req_data(mem_req_data), .mem_req_tag(mem_req_tag),
    .xlate_valid(xlate_valid), .xlate_vaddr(xlate_vaddr),
    .xlate_paddr(xlate_paddr), .xlate_fault(xlate_fault),
    .err_valid(err_valid), .err_tag(err_tag), .irq(irq),
    .HSEL(HSEL), .HWRITE(HWRITE), .HTRANS(HTRANS), .HADDR(HADDR),
    .HWDATA(HWDATA), .HRDATA(HRDATA), .HREADYOUT(HREADYOUT), .HRESP(HRESP)
  );

  initial begin
    CLK = 1'b0;
    forever #5 CLK = ~CLK;
  end

  int n_total = 0;
  int n_bad   = 0;

  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
    n_total++;
    if (act !== exp) begin
      n_bad++;
      $display("FAIL %s got=%h want=%h t=%0t", nm, act, exp, $time);
    end
  endtask

  // ---------------- reference model (transaction level) ----------------
  typedef struct packed {
    logic [31:0] addr;
    logic [31:0] data;
    logic        rw;
    logic [3:0]  tag;
  } txn_t;

  string       m_mode;          // "pass", "wait", "retry", "replay"
  txn_t        m_outq[$];       // request visible downstream (at most one)
  txn_t        m_hold;          // parked request; addr field = vaddr
  logic [31:0] m_new_paddr;
  int          m_retries;
  logic        m_irq, m_err;
  logic [3:0]  m_err_tag;
  logic        m_rd_phase, m_wr_phase;
  logic [2:0]  m_idx;

  // snapshots taken at the falling edge
  logic        s_req_ready, s_xlate_valid, s_err;
  logic [31:0] s_hrdata;

  task automatic model_reset();
    m_mode = "pass";
    m_outq.delete();
    m_hold = '0;
    m_new_paddr = '0;
    m_retries = 0;
    m_irq = 1'b0;
    m_err = 1'b0;
    m_err_tag = '0;
    m_rd_phase = 1'b0;
    m_wr_phase = 1'b0;
    m_idx = '0;
  endtask

  function automatic logic [31:0] model_reg(input logic [2:0] idx);
    case (idx)
      3'd0:    return (m_retries << 8) | (32'(m_irq) << 1) | 32'(m_mode != "pass");
      3'd1:    return m_hold.addr;
      3'd2:    return 32'(m_hold.tag);
      default: return 32'h0;
    endcase
  endfunction

  task automatic check_outputs();
    logic exp_ready;
    exp_ready = (m_mode == "pass") && (m_outq.size() == 0 || mem_req_ready);
    chk("req_ready", req_ready, exp_ready);
    chk("mem_valid", mem_req_valid, m_outq.size() != 0);
    if (m_outq.size() != 0) begin
      chk("mem_addr", mem_req_addr, m_outq[0].addr);
      chk("mem_data", mem_req_data, m_outq[0].data);
      chk("mem_rw",   mem_req_rw,   m_outq[0].rw);
      chk("mem_tag",  mem_req_tag,  m_outq[0].tag);
    end
    chk("irq", irq, m_irq);
    chk("err_valid", err_valid, m_err);
    if (m_err) chk("err_tag", err_tag, m_err_tag);
    chk("xlate_valid", xlate_valid, m_mode == "retry");
    if (m_mode == "retry") chk("xlate_vaddr", xlate_vaddr, m_hold.addr);
    if (m_rd_phase) chk("hrdata", HRDATA, model_reg(m_idx));
    chk("hready_hresp", {HREADYOUT, HRESP}, 2'b10);
  endtask

  task automatic model_update();
    bit   slot_free, accepted, cmd;
    txn_t t;
    slot_free = (m_outq.size() == 0) || mem_req_ready;
    accepted  = req_valid && (m_mode == "pass") && slot_free;
    cmd       = m_wr_phase && (m_idx == 3'd3);
    if (m_outq.size() != 0 && mem_req_ready) void'(m_outq.pop_front());
    m_err = 1'b0;
    if (m_mode == "pass") begin
      if (accepted && req_fault) begin
        m_hold = '{addr: req_vaddr, data: req_wdata, rw: req_rw, tag: req_tag};
        m_irq = 1'b1;
        m_retries = 0;
        m_mode = "wait";
      end else if (accepted) begin
        t = '{addr: req_paddr, data: req_wdata, rw: req_rw, tag: req_tag};
        m_outq.push_back(t);
      end
    end else if (m_mode == "wait") begin
      if (cmd && HWDATA[1]) begin
        m_err = 1'b1; m_err_tag = m_hold.tag; m_irq = 1'b0; m_mode = "pass";
      end else if (cmd && HWDATA[0]) begin
        m_irq = 1'b0; m_mode = "retry";
      end
    end else if (m_mode == "retry") begin
      if (xlate_fault) begin
        if (m_retries < 255) m_retries++;
        m_irq = 1'b1; m_mode = "wait";
      end else begin
        m_new_paddr = xlate_paddr; m_mode = "replay";
      end
    end else if (slot_free) begin
      t = '{addr: m_new_paddr, data: m_hold.data, rw: m_hold.rw, tag: m_hold.tag};
      m_outq.push_back(t);
      m_mode = "pass";
    end
    m_rd_phase = HSEL && (HTRANS == 2'b10) && !HWRITE;
    m_wr_phase = HSEL && (HTRANS == 2'b10) && HWRITE;
    m_idx      = HADDR[4:2];
  endtask

  // one clock: check at the falling edge, advance the model, return at posedge+1
  task automatic step();
    @(negedge CLK);
    s_req_ready   = req_ready;
    s_xlate_valid = xlate_valid;
    s_err         = err_valid;
    s_hrdata      = HRDATA;
    if (nRST) model_reset();
    check_outputs();
    if (!nRST) model_update();
    @(posedge CLK);
    #1;
  endtask

  task automatic idle();
    req_valid = 0; req_rw = 0; req_fault = 0; req_tag = '0;
    req_vaddr = '0; req_paddr = '0; req_wdata = '0;
    mem_req_ready = 1; xlate_fault = 0; xlate_paddr = '0;
    HSEL = 0; HWRITE = 0; HTRANS = 2'b00; HADDR = '0; HWDATA = '0;
  endtask

  task automatic drive_req(input logic [31:0] va, input logic [31:0] pa,
                           input logic [31:0] wd, input logic f, input logic [3:0] tg);
    req_valid = 1; req_vaddr = va; req_paddr = pa; req_wdata = wd;
    req_fault = f; req_tag = tg; req_rw = wd[0];
  endtask

  task automatic ahb_read(input logic [2:0] idx, output logic [31:0] d);
    HSEL = 1; HTRANS = 2'b10; HWRITE = 0; HADDR = {27'h0, idx, 2'b00};
    step();
    HSEL = 0; HTRANS = 2'b00;
    step();
    d = s_hrdata;
  endtask

  task automatic ahb_write(input logic [2:0] idx, input logic [31:0] d);
    HSEL = 1; HTRANS = 2'b10; HWRITE = 1; HADDR = {27'h0, idx, 2'b00};
    step();
    HSEL = 0; HTRANS = 2'b00; HWRITE = 0; HWDATA = d;
    step();
  endtask

  initial begin
    logic [31:0] rd;
    int          ahb_ph;
    idle();
    model_reset();
    nRST = 1;
    #3;
    chk("rst_mem_valid", mem_req_valid, 0);
    chk("rst_req_ready", req_ready, 1);
    chk("rst_irq", irq, 0);
    chk("rst_err", err_valid, 0);
    chk("rst_xlate", xlate_valid, 0);
    chk("rst_hrdata", HRDATA, 0);
    @(posedge CLK); #1;
    step();
    nRST = 0;
    step();

    // clean stream, one cycle latency, no stall
    drive_req(32'h1000, 32'h2000, 32'hA0, 0, 4'd1); step();
    chk("s1_ready", s_req_ready, 1); chk("s1_addr", mem_req_addr, 32'h2000);
    drive_req(32'h1004, 32'h2004, 32'hA2, 0, 4'd2); step();
    chk("s2_ready", s_req_ready, 1); chk("s2_addr", mem_req_addr, 32'h2004);
    drive_req(32'h1008, 32'h2008, 32'hA4, 0, 4'd3); step();
    chk("s3_ready", s_req_ready, 1); chk("s3_addr", mem_req_addr, 32'h2008);
    req_valid = 0; step();
    chk("s_drained", mem_req_valid, 0);

    // backpressure
    mem_req_ready = 0;
    drive_req(32'h0, 32'h3000, 32'hB0, 0, 4'd1); step();
    drive_req(32'h0, 32'h3004, 32'hB2, 0, 4'd2);
    for (int i = 0; i < 4; i++) begin
      step();
      chk("bp_ready", s_req_ready, 0);
      chk("bp_addr", mem_req_addr, 32'h3000);
      chk("bp_tag", mem_req_tag, 4'd1);
    end
    mem_req_ready = 1; step();
    chk("bp_release_ready", s_req_ready, 1);
    chk("bp_next_addr", mem_req_addr, 32'h3004);
    req_valid = 0; step();

    // fault, retry success
    drive_req(32'h6004, 32'h0, 32'hC0, 1, 4'd5); step();
    req_valid = 0;
    chk("f_irq", irq, 1);
    chk("f_mem_idle", mem_req_valid, 0);
    ahb_read(3'd1, rd); chk("f_vaddr", rd, 32'h6004);
    ahb_read(3'd2, rd); chk("f_tag", rd, 32'h5);
    xlate_paddr = 32'h2004; xlate_fault = 0;
    ahb_write(3'd3, 32'h1);
    chk("f_irq_clr", irq, 0);
    step(); chk("f_xlate", s_xlate_valid, 1);
    step();
    chk("f_replay_addr", mem_req_addr, 32'h2004);
    chk("f_replay_tag", mem_req_tag, 4'd5);
    chk("f_replay_valid", mem_req_valid, 1);
    ahb_read(3'd0, rd); chk("f_status", rd, 32'h0);

    // retry faults twice, then abort
    drive_req(32'h7000, 32'h0, 32'hD0, 1, 4'd9); step();
    req_valid = 0; xlate_fault = 1;
    for (int i = 0; i < 2; i++) begin
      ahb_write(3'd3, 32'h1);
      step();
    end
    chk("r_irq", irq, 1);
    ahb_read(3'd0, rd); chk("r_status", rd, 32'h0203);
    ahb_write(3'd3, 32'h2);
    chk("r_err", err_valid, 1); chk("r_err_tag", err_tag, 4'd9);
    step(); chk("r_err_once", err_valid, 0);
    ahb_read(3'd0, rd); chk("r_status_after", rd, 32'h0200);
    xlate_fault = 0;

    // CMD=3 aborts; CMD=1 in PASS does nothing
    drive_req(32'h8000, 32'h0, 32'hE0, 1, 4'd3); step();
    req_valid = 0;
    ahb_write(3'd3, 32'h3);
    chk("c3_err", err_valid, 1); chk("c3_err_tag", err_tag, 4'd3);
    step();
    ahb_write(3'd3, 32'h1);
    step(); chk("c1_no_xlate", s_xlate_valid, 0);
    ahb_read(3'd0, rd); chk("c1_status", rd, 32'h0);

    // reset in the middle of a fault
    drive_req(32'h9000, 32'h0, 32'hF0, 1, 4'd7); step();
    req_valid = 0;
    nRST = 1; #1;
    chk("mr_irq", irq, 0); chk("mr_mem", mem_req_valid, 0);
    chk("mr_err", err_valid, 0); chk("mr_xlate", xlate_valid, 0);
    chk("mr_ready", req_ready, 1);
    step();
    nRST = 0; step();
    chk("mr_no_err", s_err, 0);
    drive_req(32'h0, 32'h4000, 32'h11, 0, 4'd4); step();
    req_valid = 0;
    chk("mr_clean_addr", mem_req_addr, 32'h4000);
    ahb_read(3'd0, rd); chk("mr_status", rd, 32'h0);

    // randomized traffic against the model
    ahb_ph = 0;
    for (int c = 0; c < 4000; c++) begin
      req_valid = ($urandom_range(0, 1) == 1);
      req_fault = ($urandom_range(0, 4) == 0);
      req_rw    = $urandom_range(0, 1);
      req_vaddr = $urandom; req_paddr = $urandom; req_wdata = $urandom;
      req_tag   = 4'($urandom);
      mem_req_ready = ($urandom_range(0, 9) < 7);
      xlate_fault   = ($urandom_range(0, 9) < 4);
      xlate_paddr   = $urandom;
      if (ahb_ph == 1) begin
        HSEL = 0; HTRANS = 2'b00;
        HWDATA = ($urandom & 32'hFFFF_FFFC) | 32'($urandom_range(0, 3));
        ahb_ph = 0;
      end else if ($urandom_range(0, 5) == 0) begin
        HSEL = 1;
        HTRANS = ($urandom_range(0, 7) == 0) ? 2'b00 : 2'b10;
        HWRITE = $urandom_range(0, 1);
        HADDR  = ($urandom & 32'hFFFF_FFE3) |
                 {27'h0, ($urandom_range(0, 1) == 1) ? 3'd3 : 3'($urandom), 2'b00};
        ahb_ph = 1;
      end else begin
        HSEL = 0; HTRANS = 2'b00;
      end
      nRST = ($urandom_range(0, 599) == 0);
      step();
    end
    nRST = 0;
    idle();
    step();

    $display("test done: total=%0d bad=%0d", n_total, n_bad);
    $finish;
  end

endmodule
`default_nettype wire

// File: doc/pf_replay_buffer.md
PF_REPLAY_BUFFER -- requirements
Module: pf_replay_buffer

Interface
REQ-001 Parameter TAG_W, default 4, request tag width.
REQ-002 Parameter ADDR_W, default 32, address/data width.
REQ-003 CLK  in  1  single clock; all state on rising edge.
REQ-004 nRST  in  1  reset, asynchronous, active-high (asserted = 1).
REQ-005 req_valid, req_rw  in  1 each  upstream request valid; 1 = write.
REQ-006 req_ready  out  1  upstream request accepted when req_valid & req_ready.
REQ-007 req_vaddr, req_paddr, req_wdata  in  ADDR_W each  virtual address, translated address, write data.
REQ-008 req_fault  in  1  page fault flag from translator; req_tag  in  TAG_W.
REQ-009 mem_req_valid, mem_req_rw  out  1 each; mem_req_ready  in  1  downstream handshake.
REQ-010 mem_req_addr, mem_req_data  out  ADDR_W each; mem_req_tag  out  TAG_W.
REQ-011 xlate_valid  out  1; xlate_vaddr  out  ADDR_W  re-lookup to page table; xlate_paddr  in  ADDR_W; xlate_fault  in  1 (same-cycle combinational result).
REQ-012 err_valid  out  1; err_tag  out  TAG_W  aborted-request notification.
REQ-013 irq  out  1  fault pending interrupt.
REQ-014 HSEL, HWRITE  in  1; HTRANS  in  2; HADDR, HWDATA  in  32; HRDATA  out  32; HREADYOUT  out  1; HRESP  out  1  AHB-lite slave.

Function
REQ-015 FSM states: PASS, FAULT_WAIT, RETRY, REPLAY.
REQ-016 One-entry output register (out_valid, addr, data, rw, tag) drives mem_req_*; contents held stable while mem_req_valid & ~mem_req_ready.
REQ-017 PASS: req_ready = ~out_valid | mem_req_ready; other states: req_ready = 0.
REQ-018 PASS, accepted req with req_fault=0: output register loaded with req_paddr next cycle; latency 1 cycle; full throughput when mem_req_ready=1.
REQ-019 PASS, accepted req with req_fault=1: vaddr/wdata/rw/tag captured in hold register, irq set, retry_cnt cleared, go FAULT_WAIT; nothing sent downstream.
REQ-020 Output register drains independently of FSM state.
REQ-021 FAULT_WAIT: CMD write bit1=1 -> abort: err_valid=1 with held tag for exactly one cycle, irq cleared, go PASS.
REQ-022 FAULT_WAIT: CMD write bit0=1, bit1=0 -> go RETRY, irq cleared.
REQ-023 RETRY (1 cycle): xlate_valid=1, xlate_vaddr=held vaddr; xlate_fault=1 -> retry_cnt += 1 (saturate 255), irq set, go FAULT_WAIT; else capture xlate_paddr, go REPLAY.
REQ-024 REPLAY: when ~out_valid | mem_req_ready, load output register with captured paddr and held fields, go PASS.
REQ-025 CMD writes outside FAULT_WAIT ignored; CMD bits both 0 ignored.
REQ-026 AHB: transfer on HSEL & HTRANS==2'b10; address/control registered in address phase, write applied in data phase using HWDATA.
REQ-027 Register map (word offsets HADDR[4:2]): 0x00 STATUS RO {retry_cnt[15:8], irq[1], pending[0]}; 0x04 FAULT_VADDR RO; 0x08 FAULT_TAG RO (zero-extended); 0x0C CMD WO (reads 0); others read 0, writes ignored.
REQ-028 pending = 1 in FAULT_WAIT, RETRY, REPLAY.
REQ-029 HRDATA valid in data phase; HREADYOUT = 1 always; HRESP = 0 always.
REQ-030 Writes to RO registers ignored.

Reset
REQ-031 nRST=1 asynchronously forces: state PASS, out_valid=0, mem_req_valid=0, req_ready reflects PASS/empty (1 after reset release), irq=0, err_valid=0, xlate_valid=0, retry_cnt=0, hold/fault registers 0, HRDATA=0, AHB phase registers cleared.
REQ-032 Reset mid-fault or mid-replay drops the held request silently; no err_valid pulse.

Verification
REQ-033 Clean stream: 3 reqs, fault=0, paddr 0x2000/0x2004/0x2008, mem_req_ready=1 -> mem_req_addr same order, 1 cycle after each accept, no stall.
REQ-034 Backpressure: mem_req_ready=0 for 4 cycles with out_valid=1 -> mem_req_* stable, req_ready=0; on ready release next req accepted same cycle.
REQ-035 Fault+retry success: req vaddr 0x6004 fault=1, tag 5 -> irq=1, FAULT_VADDR=0x6004; CMD=1, xlate returns 0x2004 fault=0 -> mem_req_addr=0x2004 tag 5, irq=0, STATUS=0.
REQ-036 Retry fault twice then abort: CMD=1 with xlate_fault=1 twice -> STATUS[15:8]=2, irq=1; CMD=2 -> err_valid one cycle, err_tag=held tag, back to PASS.
REQ-037 CMD=3 in FAULT_WAIT -> abort behaviour; CMD=1 in PASS -> no state change, no xlate_valid.
REQ-038 nRST pulse during FAULT_WAIT -> all outputs at reset values, no err_valid, next clean req passes normally.
